// File: rtl/comparator.sv
// Signed zero/sign comparator on a pre-formed difference.
module comparator #(
  parameter int unsigned WIDTH = 9
) (
  input  logic signed [WIDTH-1:0] dIn,
  output logic                    equal,
  output logic                    less
);

  // Difference is already overflow-free, so the sign bit alone gives "less".
  always_comb begin
    equal = (dIn == '0);
    less  = dIn[WIDTH-1];
  end

endmodule

// File: rtl/cmp_scheduler.sv
// Round-robin scheduler sharing one comparator among NREQ branch-resolution requesters.
module cmp_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         reqValid,
  output logic [NREQ-1:0]         reqReady,
  input  logic [NREQ*WIDTH-1:0]   reqA,
  input  logic [NREQ*WIDTH-1:0]   reqB,
  input  logic [NREQ*3-1:0]       reqCond,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [IDW-1:0]          rspId,
  output logic                    rspTaken,
  output logic                    rspEqual,
  output logic                    rspLess
);

  typedef enum logic [1:0] {StIdle, StCmp, StHold} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant;
  logic                   any_valid;
  logic                   accept;
  int unsigned            idx;

  logic [WIDTH-1:0]       sel_a, sel_b;
  logic signed [WIDTH:0]  a_ext, b_ext;
  logic signed [WIDTH:0]  diff_q;
  logic [2:0]             cond_q;
  logic [IDW-1:0]         id_q;
  logic                   cmp_equal, cmp_less;
  logic                   taken;

  // Round-robin search from ptr; walking offsets high-to-low lets the lowest offset win.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + NREQ - 1 - i) % NREQ;
      if (reqValid[idx]) begin
        grant     = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign accept = (state_q == StIdle) && any_valid;

  // Operand selection and widened subtraction for the granted requester.
  always_comb begin
    sel_a = reqA[grant*WIDTH +: WIDTH];
    sel_b = reqB[grant*WIDTH +: WIDTH];
    a_ext = {sel_a[WIDTH-1], sel_a};
    b_ext = {sel_b[WIDTH-1], sel_b};
  end

  comparator #(
    .WIDTH (WIDTH + 1)
  ) u_comparator (
    .dIn   (diff_q),
    .equal (cmp_equal),
    .less  (cmp_less)
  );

  // Condition-code decode against the live comparator outputs.
  always_comb begin
    unique case (cond_q)
      3'b000:  taken = cmp_equal;
      3'b001:  taken = !cmp_equal;
      3'b010:  taken = cmp_less;
      3'b011:  taken = !cmp_less;
      3'b100:  taken = !cmp_less && !cmp_equal;
      3'b101:  taken = cmp_less || cmp_equal;
      3'b110:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StCmp;
          ptr_d   = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        end
      end
      StCmp:   state_d = StHold;
      StHold:  if (rspReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs; reqReady depends only on state, ptr and reqValid.
  always_comb begin
    reqReady = '0;
    rspValid = (state_q == StHold);
    if (accept) reqReady[grant] = 1'b1;
  end

  // Request capture on accept, response capture at the end of the compare cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q   <= '0;
      cond_q   <= '0;
      id_q     <= '0;
      rspId    <= '0;
      rspTaken <= 1'b0;
      rspEqual <= 1'b0;
      rspLess  <= 1'b0;
    end else begin
      if (accept) begin
        diff_q <= a_ext - b_ext;
        cond_q <= reqCond[grant*3 +: 3];
        id_q   <= grant;
      end
      if (state_q == StCmp) begin
        rspId    <= id_q;
        rspTaken <= taken;
        rspEqual <= cmp_equal;
        rspLess  <= cmp_less;
      end
    end
  end

endmodule

// File: tb/tb_cmp_scheduler.sv
// Directed self-checking bench for cmp_scheduler.
module tb_cmp_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [31:0] reqA, reqB;
  logic [11:0] reqCond;
  logic        rspValid, rspReady;
  logic [1:0]  rspId;
  logic        rspTaken, rspEqual, rspLess;

  int tests = 0;
  int fails = 0;

  cmp_scheduler #(
    .WIDTH (8),
    .NREQ  (4),
    .IDW   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqA     (reqA),
    .reqB     (reqB),
    .reqCond  (reqCond),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspId    (rspId),
    .rspTaken (rspTaken),
    .rspEqual (rspEqual),
    .rspLess  (rspLess)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] c);
    reqValid[r]      = 1'b1;
    reqA[r*8 +: 8]   = a;
    reqB[r*8 +: 8]   = b;
    reqCond[r*3 +: 3] = c;
  endtask

  // One full transaction from a single requester, checking latency and fields.
  task automatic do_req(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, input logic et, input logic ee,
                        input logic el, input string tag);
    logic found;
    rspReady = 1'b0;
    set_req(r, a, b, c);
    #1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (reqReady[r]) found = 1'b1;
      else tick;
    end
    chk({tag, " granted"}, 32'(found), 32'd1);
    chk({tag, " reqReady"}, 32'(reqReady), 32'd1 << r);
    tick;
    reqValid[r] = 1'b0;
    #1;
    chk({tag, " rspValid in CMP"}, 32'(rspValid), 32'd0);
    chk({tag, " reqReady in CMP"}, 32'(reqReady), 32'd0);
    tick;
    chk({tag, " rspValid"}, 32'(rspValid), 32'd1);
    chk({tag, " rspId"}, 32'(rspId), 32'(r));
    chk({tag, " rspTaken"}, 32'(rspTaken), 32'(et));
    chk({tag, " rspEqual"}, 32'(rspEqual), 32'(ee));
    chk({tag, " rspLess"}, 32'(rspLess), 32'(el));
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    chk({tag, " rspValid after consume"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    int exp_g [6];
    int n_acc, n_rsp, last, g, xfers, d;
    logic [7:0] tab;

    rst_n    = 1'b0;
    reqValid = '0;
    reqA     = '0;
    reqB     = '0;
    reqCond  = '0;
    rspReady = 1'b0;
    tick;
    tick;
    chk("reset rspValid", 32'(rspValid), 32'd0);
    chk("reset rspId", 32'(rspId), 32'd0);
    chk("reset rspTaken", 32'(rspTaken), 32'd0);
    chk("reset rspEqual", 32'(rspEqual), 32'd0);
    chk("reset rspLess", 32'(rspLess), 32'd0);
    chk("reset reqReady", 32'(reqReady), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle no request reqReady", 32'(reqReady), 32'd0);

    // Single request, equal operands.
    do_req(1, 8'd5, 8'd5, 3'b000, 1'b1, 1'b1, 1'b0, "single EQ");

    // Overflow boundaries.
    do_req(2, 8'h80, 8'h7f, 3'b010, 1'b1, 1'b0, 1'b1, "ovf -128 LT 127");
    do_req(3, 8'h7f, 8'h80, 3'b100, 1'b1, 1'b0, 1'b0, "ovf 127 GT -128");

    // Condition sweep at A-B = -1, 0, +1 (bit c of tab is the expected taken for cond c).
    for (int di = 0; di < 3; di++) begin
      d   = di - 1;
      tab = (di == 0) ? 8'b0110_0110 : (di == 1) ? 8'b0110_1001 : 8'b0101_1010;
      for (int c = 0; c < 8; c++) begin
        do_req(c % 4, 8'(d - 3), 8'hfd, 3'(c), tab[c], (d == 0), (d < 0),
               $sformatf("sweep d=%0d c=%0d", d, c));
      end
    end

    // Round-robin fairness with all requesters valid and no backpressure.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 8'(r), 8'd2, 3'b010);
    rspReady = 1'b1;
    exp_g = '{0, 1, 2, 3, 0, 1};
    n_acc = 0;
    n_rsp = 0;
    last  = 0;
    #1;
    for (int cyc = 0; cyc < 30 && n_acc < 6; cyc++) begin
      if (reqReady != 4'b0000) begin
        chk("rr onehot", 32'($onehot(reqReady)), 32'd1);
        g = 0;
        for (int b = 0; b < 4; b++) if (reqReady[b]) g = b;
        chk($sformatf("rr grant %0d", n_acc), 32'(g), 32'(exp_g[n_acc]));
        if (n_acc > 0) chk($sformatf("rr gap %0d", n_acc), 32'(cyc - last), 32'd3);
        last = cyc;
        n_acc++;
      end
      if (rspValid && n_rsp < 6) begin
        chk($sformatf("rr rspId %0d", n_rsp), 32'(rspId), 32'(exp_g[n_rsp]));
        chk($sformatf("rr rspTaken %0d", n_rsp), 32'(rspTaken),
            32'(exp_g[n_rsp] < 2));
        n_rsp++;
      end
      tick;
    end
    chk("rr accept count", 32'(n_acc), 32'd6);
    reqValid = '0;
    tick;
    tick;
    tick;
    rspReady = 1'b0;

    // Backpressure: hold the response 10 cycles while other requesters wait.
    set_req(2, 8'd3, 8'd9, 3'b010);
    #1;
    chk("bp reqReady", 32'(reqReady), 32'b0100);
    tick;
    reqValid = '0;
    tick;
    reqValid = 4'b1011;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp rspValid %0d", k), 32'(rspValid), 32'd1);
      chk($sformatf("bp rspId %0d", k), 32'(rspId), 32'd2);
      chk($sformatf("bp rspTaken %0d", k), 32'(rspTaken), 32'd1);
      chk($sformatf("bp rspLess %0d", k), 32'(rspLess), 32'd1);
      chk($sformatf("bp rspEqual %0d", k), 32'(rspEqual), 32'd0);
      chk($sformatf("bp reqReady %0d", k), 32'(reqReady), 32'd0);
      tick;
    end
    reqValid = '0;
    rspReady = 1'b1;
    xfers = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (rspValid && rspReady) xfers++;
      tick;
    end
    chk("bp transfer count", 32'(xfers), 32'd1);
    rspReady = 1'b0;

    // Reset right after an accept discards the request and clears ptr.
    set_req(1, 8'd20, 8'd7, 3'b011);
    #1;
    chk("rst grant 1", 32'(reqReady), 32'b0010);
    tick;
    reqValid = '0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst rspValid", 32'(rspValid), 32'd0);
    chk("rst rspId", 32'(rspId), 32'd0);
    chk("rst rspTaken", 32'(rspTaken), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("rst no response %0d", k), 32'(rspValid), 32'd0);
    end
    reqValid = 4'b1111;
    #1;
    chk("rst ptr back to 0", 32'(reqReady), 32'b0001);
    reqValid = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
